// File: rtl/kurm_mem_pkg.sv
// Shared constants and state encoding for the data-memory access path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kurm_mem_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;
    localparam int MEM_DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mau_state_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory with a registered read port and no reset.
// Latency: write and read both act at the edge that samples the strobe; readData valid after that edge.
// Backpressure: none; always accepts a strobe. Out-of-range addresses are ignored.
module data_memory #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                  clock,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

    localparam int IW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  in_range;

    assign in_range = (addr < ADDR_WIDTH'(DEPTH));

    // Array write and registered read; storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (memWrite && in_range) begin
            mem[addr[IW-1:0]] <= writeData;
        end
        if (memRead && in_range) begin
            readData <= mem[addr[IW-1:0]];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for the registered-read data memory.
// Latency: accept-to-resp_valid = 3 edges (load), 2 (store), 1 (out-of-range fault).
// Backpressure: resp_ready low parks the unit in RESP with outputs held; req_ready stays low until the response is taken.
module mem_access_unit #(
    parameter int ADDR_WIDTH = kurm_mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = kurm_mem_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH  = kurm_mem_pkg::MEM_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    import kurm_mem_pkg::*;

    // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    mau_state_t            state, state_n;
    logic                  write_q, write_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic [DATA_WIDTH-1:0] mem_wdata_n;
    logic                  mem_read_n, mem_write_n;
    logic [DATA_WIDTH-1:0] resp_rdata_n;
    logic                  resp_fault_n;
    logic                  addr_fault;

    assign req_ready  = (state == IDLE) && !reset;
    assign resp_valid = (state == RESP);
    assign addr_fault = ({1'b0, req_addr} >= DEPTH_EXT);

    // State and output registers; the memory itself is not reset, so a strobe
    // already on the wire at a reset edge still takes effect there.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            write_q    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            state      <= state_n;
            write_q    <= write_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_read   <= mem_read_n;
            mem_write  <= mem_write_n;
            resp_rdata <= resp_rdata_n;
            resp_fault <= resp_fault_n;
        end
    end

    // Next-state and next-output decode; strobes default low so each lasts one cycle.
    always_comb begin
        state_n      = state;
        write_n      = write_q;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_read_n   = 1'b0;
        mem_write_n  = 1'b0;
        resp_rdata_n = resp_rdata;
        resp_fault_n = resp_fault;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    write_n = req_write;
                    if (addr_fault) begin
                        // Out of range: answer immediately, never touch the memory.
                        state_n      = RESP;
                        resp_fault_n = 1'b1;
                        resp_rdata_n = '0;
                    end else begin
                        state_n     = ISSUE;
                        mem_addr_n  = req_addr;
                        mem_wdata_n = req_wdata;
                        mem_read_n  = !req_write;
                        mem_write_n = req_write;
                    end
                end
            end
            ISSUE: begin
                // Memory acts on the edge closing this cycle.
                state_n = write_q ? RESP : WAIT;
            end
            WAIT: begin
                // Registered read data is valid one cycle after the read strobe.
                resp_rdata_n = mem_rdata;
                state_n      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_n      = IDLE;
                    resp_rdata_n = '0;
                    resp_fault_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit driving a data_memory responder.
// Latency: n/a.
// Backpressure: exercised by holding resp_ready low.
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [15:0] resp_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    // Bench-side preload path into the memory, used only while the unit is in reset.
    logic        pre_en, pre_we;
    logic [15:0] pre_addr, pre_wdata;
    logic [15:0] m_addr, m_wdata;
    logic        m_read, m_write;

    assign m_addr  = pre_en ? pre_addr  : mem_addr;
    assign m_wdata = pre_en ? pre_wdata : mem_wdata;
    assign m_read  = pre_en ? 1'b0      : mem_read;
    assign m_write = pre_en ? pre_we    : mem_write;

    mem_access_unit dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    data_memory u_mem (
        .clock     (clock),
        .addr      (m_addr),
        .memRead   (m_read),
        .memWrite  (m_write),
        .writeData (m_wdata),
        .readData  (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          acc_cyc = 0;
    int          prev_acc = 0;
    logic [16:0] exp_q [$];
    logic [16:0] sb_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_req(input string name, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp_rdata,
                          input logic exp_fault, input int exp_lat,
                          input int exp_rd, input int exp_wr);
        int n;
        int rd0;
        int wr0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!req_ready) chk({name, "_ready"}, {31'b0, req_ready}, 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back({exp_fault, exp_rdata});
        @(posedge clock); #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 10) begin
            @(posedge clock); #1;
            n++;
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_mem_read_cycles"}, rd_cnt - rd0, exp_rd);
        chk({name, "_mem_write_cycles"}, wr_cnt - wr0, exp_wr);
        @(posedge clock); #1;
        chk({name, "_resp_dropped"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        pre_en     = 1'b1;
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_wdata  = '0;

        fork
            forever begin
                @(posedge clock);
                cyc++;
            end
            // Monitor: strobe counting and scoreboard pop on every response handshake.
            forever begin
                @(negedge clock);
                if (mem_read)  rd_cnt++;
                if (mem_write) wr_cnt++;
                if (!reset && resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp: got rdata=%0h fault=%0b expected none",
                                 resp_rdata, resp_fault);
                    end else begin
                        sb_e = exp_q.pop_front();
                        chk("resp_rdata", {16'b0, resp_rdata}, {16'b0, sb_e[15:0]});
                        chk("resp_fault", {31'b0, resp_fault}, {31'b0, sb_e[16]});
                    end
                end
            end
            begin
                #400000;
                $display("FAIL watchdog: got timeout expected completion");
                $display("test done: total=%0d bad=%0d", total, bad + 1);
                $fatal(1, "watchdog");
            end
        join_none

        // Preload addr 0 = 2 and addr 1 = 10 while the unit is held in reset.
        @(posedge clock); #1;
        pre_we = 1'b1; pre_addr = 16'd0; pre_wdata = 16'd2;
        @(posedge clock); #1;
        pre_addr = 16'd1; pre_wdata = 16'd10;
        @(posedge clock); #1;
        pre_we = 1'b0; pre_en = 1'b0;

        @(negedge clock);
        chk("rst_req_ready",  {31'b0, req_ready},  32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_strobes",    {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_resp_rdata", {16'b0, resp_rdata}, 32'd0);
        chk("rst_mem_addr",   {16'b0, mem_addr},   32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("rst_release_ready", {31'b0, req_ready}, 32'd1);

        // Basic load, store, load-back, and fault.
        do_req("load0",     1'b0, 16'd0,    16'd0,  16'd2,  1'b0, 3, 1, 0);
        do_req("store5",    1'b1, 16'd5,    16'd15, 16'd0,  1'b0, 2, 0, 1);
        do_req("load5",     1'b0, 16'd5,    16'd0,  16'd15, 1'b0, 3, 1, 0);
        do_req("fault1024", 1'b0, 16'd1024, 16'd0,  16'd0,  1'b1, 1, 0, 0);
        do_req("fault_max", 1'b1, 16'hFFFF, 16'd7,  16'd0,  1'b1, 1, 0, 0);

        // Backpressure: response held while resp_ready is low, competing request ignored.
        begin
            int n;
            int wr0;
            resp_ready = 1'b0;
            wr0 = wr_cnt;
            exp_q.push_back({1'b0, 16'd10});
            req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd1;
            @(posedge clock); #1;
            req_valid = 1'b0;
            n = 1;
            while (!resp_valid && n < 10) begin
                @(posedge clock); #1;
                n++;
            end
            chk("bp_latency", n, 3);
            req_valid = 1'b1; req_write = 1'b1; req_addr = 16'd2; req_wdata = 16'h1234;
            for (int i = 0; i < 4; i++) begin
                @(posedge clock); #1;
                chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
                chk("bp_resp_rdata", {16'b0, resp_rdata}, 32'd10);
                chk("bp_req_ready",  {31'b0, req_ready},  32'd0);
            end
            req_valid = 1'b0;
            chk("bp_no_store", wr_cnt - wr0, 0);
            resp_ready = 1'b1;
            @(posedge clock); #1;
            chk("bp_released", {31'b0, resp_valid}, 32'd0);
        end

        // Reset while a load sits in WAIT: no response, everything cleared.
        begin
            int seen;
            req_valid = 1'b1; req_write = 1'b0; req_addr = 16'd5;
            @(posedge clock); #1;
            req_valid = 1'b0;
            @(posedge clock); #1;
            reset = 1'b1;
            @(posedge clock); #1;
            chk("rw_resp_valid", {31'b0, resp_valid}, 32'd0);
            chk("rw_resp_rdata", {16'b0, resp_rdata}, 32'd0);
            chk("rw_resp_fault", {31'b0, resp_fault}, 32'd0);
            chk("rw_strobes",    {30'b0, mem_read, mem_write}, 32'd0);
            chk("rw_mem_addr",   {16'b0, mem_addr},   32'd0);
            chk("rw_req_ready_in_reset", {31'b0, req_ready}, 32'd0);
            reset = 1'b0;
            #1;
            chk("rw_req_ready_after", {31'b0, req_ready}, 32'd1);
            seen = 0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clock); #1;
                if (resp_valid) seen++;
            end
            chk("rw_no_response", seen, 0);
        end

        // Back-to-back stores then loads; check data order and issue spacing.
        do_req("bb_st_3ff", 1'b1, 16'h03FF, 16'hAAAA, 16'd0, 1'b0, 2, 0, 1);
        prev_acc = acc_cyc;
        do_req("bb_st_0",   1'b1, 16'h0000, 16'h0001, 16'd0, 1'b0, 2, 0, 1);
        chk("bb_store_period", acc_cyc - prev_acc, 3);
        prev_acc = acc_cyc;
        do_req("bb_st_7",   1'b1, 16'h0007, 16'hFFFF, 16'd0, 1'b0, 2, 0, 1);
        chk("bb_store_period2", acc_cyc - prev_acc, 3);
        do_req("bb_ld_3ff", 1'b0, 16'h03FF, 16'd0, 16'hAAAA, 1'b0, 3, 1, 0);
        prev_acc = acc_cyc;
        do_req("bb_ld_0",   1'b0, 16'h0000, 16'd0, 16'h0001, 1'b0, 3, 1, 0);
        chk("bb_load_period", acc_cyc - prev_acc, 4);
        prev_acc = acc_cyc;
        do_req("bb_ld_7",   1'b0, 16'h0007, 16'd0, 16'hFFFF, 1'b0, 3, 1, 0);
        chk("bb_load_period2", acc_cyc - prev_acc, 4);

        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
